mac_vec: RTL and testbench

- Parametrised successor to the single-lane MAC in the datapath.
- Accepts a signed or unsigned operand stream `in` and weight stream `w` on independent strobes, and pairs them through one-entry holding registers.
- Multiplies each pair in a registered stage and accumulates a run-time-selectable number of products (1..N_MAX) per dot product.
- Emits one result per vector with a single-cycle valid pulse, without bubbles between back-to-back vectors.
- Sits between the operand/weight fetch units and the activation stage.

---
 rtl/mac_pkg.sv | 23 ++
 rtl/mac_pair_buf.sv | 84 ++++++++
 rtl/mac_vec.sv | 114 +++++++++++
 tb/tb_mac_vec.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and helpers for the vector multiply-accumulate datapath.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_W  = 2'd1,
    WAIT_IN = 2'd2
  } pair_state_t;

  function automatic int acc_width(input int k, input int n_max);
    return 2 * k + $clog2(n_max);
  endfunction

  function automatic int len_width(input int n_max);
    return $clog2(n_max + 1);
  endfunction

  // Fill bit used when widening an operand or product.
  function automatic logic ext_bit(input logic msb, input logic is_signed);
    return is_signed & msb;
  endfunction

endpackage

// File: rtl/mac_pair_buf.sv
// Pairs operand and weight strobes through one-entry holds; flags strobes
// that arrive with nothing to pair against.
module mac_pair_buf
  import mac_pkg::*;
#(
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic [K-1:0] in,
  input  logic         data_strobe_in,
  input  logic [K-1:0] w,
  input  logic         data_strobe_w,
  output logic         in_ready,
  output logic         w_ready,
  output logic         fire,
  output logic [K-1:0] fire_in,
  output logic [K-1:0] fire_w,
  output logic         err_ovf,
  output logic         idle
);

  pair_state_t  state;
  logic [K-1:0] hold_in;
  logic [K-1:0] hold_w;

  assign in_ready = (state != WAIT_W)  || data_strobe_w;
  assign w_ready  = (state != WAIT_IN) || data_strobe_in;
  assign idle     = (state == IDLE);

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    fire    = 1'b0;
    fire_in = in;
    fire_w  = w;
    case (state)
      IDLE:    fire = data_strobe_in && data_strobe_w;
      WAIT_W:  begin fire = data_strobe_w;  fire_in = hold_in; end
      WAIT_IN: begin fire = data_strobe_in; fire_w  = hold_w;  end
      default: fire = 1'b0;
    endcase
    if (clear) fire = 1'b0;
  end

  // NOTE: state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      hold_in <= '0;
      hold_w  <= '0;
      err_ovf <= 1'b0;
    end else if (clear) begin
      state   <= IDLE;
      hold_in <= '0;
      hold_w  <= '0;
    end else begin
      if ((data_strobe_in && !in_ready) || (data_strobe_w && !w_ready))
        err_ovf <= 1'b1;
      case (state)
        IDLE: begin
          if (data_strobe_in && !data_strobe_w) begin
            hold_in <= in;
            state   <= WAIT_W;
          end else if (data_strobe_w && !data_strobe_in) begin
            hold_w <= w;
            state  <= WAIT_IN;
          end
        end
        // A pair fires from the hold; a simultaneous new operand refills it.
        WAIT_W: if (data_strobe_w) begin
          if (data_strobe_in) hold_in <= in;
          else                state   <= IDLE;
        end
        WAIT_IN: if (data_strobe_in) begin
          if (data_strobe_w) hold_w <= w;
          else               state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mac_vec.sv
// Vector MAC: pairs operand/weight streams, multiplies in a registered stage
// and accumulates vec_len products per dot product, one result pulse each.
module mac_vec
  import mac_pkg::*;
#(
  parameter int K      = 4,
  parameter int N_MAX  = 4,
  parameter int SIGNED = 1,
  parameter int ACC_W  = acc_width(K, N_MAX),
  parameter int LW     = len_width(N_MAX)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [K-1:0]     in,
  input  logic             data_strobe_in,
  input  logic [K-1:0]     w,
  input  logic             data_strobe_w,
  output logic             in_ready,
  output logic             w_ready,
  input  logic [LW-1:0]    vec_len,
  input  logic             clear,
  output logic [ACC_W-1:0] mac_out,
  output logic             out_valid,
  output logic             busy,
  output logic             err_ovf
);

  localparam logic IS_SIGNED = (SIGNED != 0);

  logic         fire, pair_idle;
  logic [K-1:0] fire_in, fire_w;

  mac_pair_buf #(.K(K)) u_pair_buf (
    .clk            (clk),
    .reset          (reset),
    .clear          (clear),
    .in             (in),
    .data_strobe_in (data_strobe_in),
    .w              (w),
    .data_strobe_w  (data_strobe_w),
    .in_ready       (in_ready),
    .w_ready        (w_ready),
    .fire           (fire),
    .fire_in        (fire_in),
    .fire_w         (fire_w),
    .err_ovf        (err_ovf),
    .idle           (pair_idle)
  );

  logic [LW-1:0] cnt, len_q, eff_len, cur_len;
  logic          first, last;

  assign eff_len = (vec_len == '0 || vec_len > LW'(N_MAX)) ? LW'(N_MAX) : vec_len;
  assign first   = (cnt == '0);
  assign cur_len = first ? eff_len : len_q;
  assign last    = (cnt == cur_len - LW'(1));

  // Operands widened to 2K so the truncated product is correct in either signedness.
  logic [2*K-1:0] op_a, op_b, prod_d;
  assign op_a   = {{K{ext_bit(fire_in[K-1], IS_SIGNED)}}, fire_in};
  assign op_b   = {{K{ext_bit(fire_w[K-1],  IS_SIGNED)}}, fire_w};
  assign prod_d = op_a * op_b;

  logic [2*K-1:0]   prod;
  logic             p_valid, p_first, p_last, a_valid;
  logic [ACC_W-1:0] acc, prod_ext, acc_sum;

  always_comb begin
    prod_ext = '0;
    prod_ext[2*K-1:0] = prod;
    for (int i = 2 * K; i < ACC_W; i++) prod_ext[i] = ext_bit(prod[2*K-1], IS_SIGNED);
  end

  assign acc_sum = (p_first ? '0 : acc) + prod_ext;
  assign busy    = !pair_idle || (cnt != '0) || p_valid || a_valid;

  // NOTE: datapath registers are reset too, since mac_out must read 0 out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      len_q     <= '0;
      prod      <= '0;
      p_valid   <= 1'b0;
      p_first   <= 1'b0;
      p_last    <= 1'b0;
      acc       <= '0;
      a_valid   <= 1'b0;
      mac_out   <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      cnt       <= '0;
      p_valid   <= 1'b0;
      a_valid   <= 1'b0;
      acc       <= '0;
      out_valid <= 1'b0;
    end else begin
      p_valid   <= fire;
      a_valid   <= p_valid;
      out_valid <= p_valid && p_last;
      if (fire) begin
        if (first) len_q <= eff_len;
        cnt     <= last ? '0 : cnt + LW'(1);
        prod    <= prod_d;
        p_first <= first;
        p_last  <= last;
      end
      if (p_valid) begin
        acc <= acc_sum;
        if (p_last) mac_out <= acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_mac_vec.sv
// Directed self-checking bench for mac_vec (signed K=4/N_MAX=4 plus an unsigned copy).
module tb_mac_vec;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] in = '0, w = '0;
  logic       data_strobe_in = 1'b0, data_strobe_w = 1'b0;
  logic       in_ready, w_ready;
  logic [2:0] vec_len = 3'd4;
  logic       clear = 1'b0;
  logic [9:0] mac_out;
  logic       out_valid, busy, err_ovf;

  logic [3:0] u_in = '0, u_w = '0;
  logic       u_sin = 1'b0, u_sw = 1'b0;
  logic       u_in_ready, u_w_ready, u_out_valid, u_busy, u_err_ovf;
  logic [9:0] u_mac_out;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] sa [8];
  logic [3:0] sb [8];
  int         ov_n;
  int         ov_cyc [8];
  logic [9:0] ov_val [8];
  logic       busy_log [32];

  mac_vec #(.K(4), .N_MAX(4), .SIGNED(1)) dut (
    .clk(clk), .reset(reset), .in(in), .data_strobe_in(data_strobe_in),
    .w(w), .data_strobe_w(data_strobe_w), .in_ready(in_ready), .w_ready(w_ready),
    .vec_len(vec_len), .clear(clear), .mac_out(mac_out), .out_valid(out_valid),
    .busy(busy), .err_ovf(err_ovf)
  );

  mac_vec #(.K(4), .N_MAX(4), .SIGNED(0)) dut_u (
    .clk(clk), .reset(reset), .in(u_in), .data_strobe_in(u_sin),
    .w(u_w), .data_strobe_w(u_sw), .in_ready(u_in_ready), .w_ready(u_w_ready),
    .vec_len(3'd4), .clear(1'b0), .mac_out(u_mac_out), .out_valid(u_out_valid),
    .busy(u_busy), .err_ovf(u_err_ovf)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives n back-to-back pairs from sa/sb, then tail idle cycles; logs pulses by cycle.
  task automatic run_stream(input int n, input int tail);
    ov_n = 0;
    for (int k = 1; k <= n + tail; k++) begin
      if (k - 1 < n) begin
        in = sa[k-1]; w = sb[k-1];
        data_strobe_in = 1'b1; data_strobe_w = 1'b1;
      end else begin
        data_strobe_in = 1'b0; data_strobe_w = 1'b0;
      end
      cyc();
      busy_log[k] = busy;
      if (out_valid && ov_n < 8) begin
        ov_cyc[ov_n] = k; ov_val[ov_n] = mac_out; ov_n++;
      end
    end
  endtask

  task automatic wait_pulse(input int max_cyc, output int got);
    got = -1;
    for (int k = 1; k <= max_cyc; k++) begin
      cyc();
      if (out_valid) begin got = k; break; end
    end
  endtask

  task automatic test_reset();
    #3;
    n_vec++; if (mac_out !== 10'd0) begin n_err++; $display("FAIL reset_mac_out: got %0d expected 0", mac_out); end
    n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_valid_busy: got %b%b expected 00", out_valid, busy); end
    n_vec++; if (err_ovf !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", err_ovf); end
    n_vec++; if (in_ready !== 1'b1 || w_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b%b expected 11", in_ready, w_ready); end
    cyc(); cyc();
    #2 reset = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    vec_len = 3'd4;
    for (int i = 0; i < 4; i++) begin sa[i] = 4'd3; sb[i] = 4'd2; end
    run_stream(4, 3);
    n_vec++; if (ov_n !== 1) begin n_err++; $display("FAIL basic_pulses: got %0d expected 1", ov_n); end
    n_vec++; if (ov_cyc[0] !== 5) begin n_err++; $display("FAIL basic_latency: got cycle %0d expected 5", ov_cyc[0]); end
    n_vec++; if (ov_val[0] !== 10'd24) begin n_err++; $display("FAIL basic_value: got %0d expected 24", ov_val[0]); end
    n_vec++; if (busy_log[5] !== 1'b1 || busy_log[6] !== 1'b0) begin n_err++; $display("FAIL basic_busy: got %b%b expected 10", busy_log[5], busy_log[6]); end
  endtask

  task automatic test_signed_extremes();
    vec_len = 3'd4;
    for (int i = 0; i < 4; i++) begin sa[i] = 4'h8; sb[i] = 4'h8; end  // -8 x -8
    run_stream(4, 3);
    n_vec++; if (ov_n !== 1 || ov_val[0] !== 10'd256) begin n_err++; $display("FAIL neg_neg: got %0d pulses value %0d expected 1 pulse 256", ov_n, $signed(ov_val[0])); end
    for (int i = 0; i < 4; i++) begin sa[i] = 4'h8; sb[i] = 4'h7; end  // -8 x 7
    run_stream(4, 3);
    n_vec++; if (ov_n !== 1 || ov_val[0] !== 10'(-224)) begin n_err++; $display("FAIL neg_pos: got %0d pulses value %0d expected 1 pulse -224", ov_n, $signed(ov_val[0])); end
  endtask

  task automatic test_unsigned();
    int got;
    got = -1;
    u_in = 4'd15; u_w = 4'd15; u_sin = 1'b1; u_sw = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    u_sin = 1'b0; u_sw = 1'b0;
    for (int k = 1; k <= 6 && got < 0; k++) begin
      cyc();
      if (u_out_valid) got = k;
    end
    n_vec++; if (got !== 1) begin n_err++; $display("FAIL unsigned_latency: got %0d expected 1", got); end
    n_vec++; if (u_mac_out !== 10'd900) begin n_err++; $display("FAIL unsigned_value: got %0d expected 900", u_mac_out); end
  endtask

  task automatic test_staggered();
    int got;
    vec_len = 3'd2;
    for (int p = 0; p < 2; p++) begin
      in = 4'd5; data_strobe_in = 1'b1; cyc(); data_strobe_in = 1'b0;
      n_vec++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL wait_w_state: got ready=%b busy=%b expected 0 1", in_ready, busy); end
      cyc();
      w = 4'd1; data_strobe_w = 1'b1; cyc(); data_strobe_w = 1'b0;
    end
    wait_pulse(4, got);
    n_vec++; if (got !== 1 || mac_out !== 10'd10) begin n_err++; $display("FAIL in_first: got cycle %0d value %0d expected 1 10", got, mac_out); end
    for (int p = 0; p < 2; p++) begin
      w = 4'd1; data_strobe_w = 1'b1; cyc(); data_strobe_w = 1'b0;
      n_vec++; if (w_ready !== 1'b0) begin n_err++; $display("FAIL wait_in_state: got w_ready=%b expected 0", w_ready); end
      cyc();
      in = 4'd5; data_strobe_in = 1'b1; cyc(); data_strobe_in = 1'b0;
    end
    wait_pulse(4, got);
    n_vec++; if (got !== 1 || mac_out !== 10'd10) begin n_err++; $display("FAIL w_first: got cycle %0d value %0d expected 1 10", got, mac_out); end
  endtask

  task automatic test_overflow();
    int got;
    vec_len = 3'd1;
    in = 4'd2; data_strobe_in = 1'b1; cyc();
    n_vec++; if (err_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_before: got %b expected 0", err_ovf); end
    in = 4'd7; #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ovf_ready: got %b expected 0", in_ready); end
    cyc(); data_strobe_in = 1'b0;
    n_vec++; if (err_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", err_ovf); end
    w = 4'd3; data_strobe_w = 1'b1; cyc(); data_strobe_w = 1'b0;
    wait_pulse(4, got);
    n_vec++; if (got !== 1 || mac_out !== 10'd6) begin n_err++; $display("FAIL ovf_held: got cycle %0d value %0d expected 1 6", got, mac_out); end
  endtask

  task automatic test_back_to_back();
    vec_len = 3'd2;
    for (int i = 0; i < 4; i++) begin sa[i] = 4'(i + 1); sb[i] = 4'(i + 1); end
    run_stream(4, 3);
    n_vec++; if (ov_n !== 2) begin n_err++; $display("FAIL b2b_pulses: got %0d expected 2", ov_n); end
    n_vec++; if (ov_cyc[0] !== 3 || ov_cyc[1] !== 5) begin n_err++; $display("FAIL b2b_spacing: got %0d,%0d expected 3,5", ov_cyc[0], ov_cyc[1]); end
    n_vec++; if (ov_val[0] !== 10'd5 || ov_val[1] !== 10'd25) begin n_err++; $display("FAIL b2b_values: got %0d,%0d expected 5,25", ov_val[0], ov_val[1]); end
    vec_len = 3'd0;
    for (int i = 0; i < 4; i++) begin sa[i] = 4'd1; sb[i] = 4'd2; end
    run_stream(4, 3);
    n_vec++; if (ov_n !== 1 || ov_cyc[0] !== 5 || ov_val[0] !== 10'd8) begin n_err++; $display("FAIL len_zero: got %0d pulses cycle %0d value %0d expected 1 5 8", ov_n, ov_cyc[0], ov_val[0]); end
  endtask

  task automatic test_clear();
    vec_len = 3'd4;
    in = 4'd5; w = 4'd5; data_strobe_in = 1'b1; data_strobe_w = 1'b1;
    cyc(); cyc();
    in = 4'd7; w = 4'd7; clear = 1'b1;
    cyc();
    clear = 1'b0; data_strobe_in = 1'b0; data_strobe_w = 1'b0;
    n_vec++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL clear_flush: got busy=%b valid=%b expected 0 0", busy, out_valid); end
    n_vec++; if (mac_out !== 10'd8 || err_ovf !== 1'b1) begin n_err++; $display("FAIL clear_retain: got %0d err=%b expected 8 1", mac_out, err_ovf); end
    for (int i = 0; i < 4; i++) begin sa[i] = 4'd1; sb[i] = 4'd1; end
    run_stream(4, 3);
    n_vec++; if (ov_n !== 1 || ov_cyc[0] !== 5 || ov_val[0] !== 10'd4) begin n_err++; $display("FAIL clear_fresh: got %0d pulses cycle %0d value %0d expected 1 5 4", ov_n, ov_cyc[0], ov_val[0]); end
  endtask

  task automatic test_async_reset();
    vec_len = 3'd4;
    in = 4'd3; w = 4'd3; data_strobe_in = 1'b1; data_strobe_w = 1'b1;
    cyc(); cyc();
    data_strobe_in = 1'b0; data_strobe_w = 1'b0;
    #1 reset = 1'b0;
    #1;
    n_vec++; if (mac_out !== 10'd0 || err_ovf !== 1'b0) begin n_err++; $display("FAIL areset_out: got %0d err=%b expected 0 0", mac_out, err_ovf); end
    n_vec++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL areset_busy: got busy=%b valid=%b expected 0 0", busy, out_valid); end
    n_vec++; if (in_ready !== 1'b1 || w_ready !== 1'b1) begin n_err++; $display("FAIL areset_ready: got %b%b expected 11", in_ready, w_ready); end
    #1 reset = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed_extremes();
    test_unsigned();
    test_staggered();
    test_overflow();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
